rr_arb_mux: RTL and testbench

Registered, parametrised N-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output. Generalises the datapath 4:1 selector: WIDTH and channel count are parameters, and selection is either round-robin fair or forced by an external select. Used in the multicycle core where several requesters (instruction fetch, data access, debug) share one downstream port such as the memory interface. Output is a single registered stage, one word per cycle sustained.

---
 rtl/rr_arb_mux.sv | 117 +++++++++++
 tb/tb_rr_arb_mux.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux
// Registered N-channel arbitrating multiplexer with valid/ready handshakes.
// Selection is round-robin fair (sel_en=0) or forced to channel sel (sel_en=1).
// A single output register stage sustains one word per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   N        channel i presents a word
//   in_ready   N        one-hot (or zero) grant, qualified by output space
//   sel_en     1        forced mode enable
//   sel        SW       forced channel index
//   out_data   WIDTH    registered selected word
//   out_chan   SW       channel that supplied out_data
//   out_valid  1        output register holds a word
//   out_ready  1        downstream accepts the held word
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               sel_en,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    last_q, last_d;

    logic             load_ok;
    logic             found;
    logic [SW-1:0]    win;
    logic             accept;
    int               idx;

    assign load_ok = ~out_valid_q | out_ready;

    // Winner search. Round-robin scans from last+1 so the previous winner
    // has lowest priority; forced mode only considers an in-range sel.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (sel_en) begin
            if (int'(sel) < N) begin
                if (in_valid[sel]) begin
                    found = 1'b1;
                    win   = sel;
                end
            end
        end else begin
            for (int off = 1; off <= N; off++) begin
                idx = (int'(last_q) + off) % N;
                if (!found && in_valid[idx]) begin
                    found = 1'b1;
                    win   = SW'(idx);
                end
            end
        end
    end

    // Grant is suppressed while reset is asserted, since the empty output
    // register would otherwise report space.
    assign accept = found & load_ok & ~reset;

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[win] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (accept) begin
            out_data_d  = in_data[int'(win)*WIDTH +: WIDTH];
            out_chan_d  = win;
            out_valid_d = 1'b1;
            last_d      = win;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: N=4 instance driven through a reference model and
// scoreboard queue, plus a small N=3 instance for out-of-range forced select.
module tb_rr_arb_mux;

    logic        clk;
    logic        reset;
    logic [31:0] dat [4];
    logic [127:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        sel_en;
    logic [1:0]  sel;
    logic [31:0] out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        sel_en3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;

    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

    rr_arb_mux #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel_en(sel_en), .sel(sel),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel_en(sel_en3), .sel(sel3),
        .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit          m_valid;
    int          m_last;
    logic [33:0] sb [$];

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = 3;
        sb.delete();
    endtask

    task automatic model_win(output bit f, output int w);
        f = 1'b0;
        w = 0;
        if (sel_en) begin
            if (in_valid[sel]) begin
                f = 1'b1;
                w = int'(sel);
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (!f && in_valid[(m_last + k) % 4]) begin
                    f = 1'b1;
                    w = (m_last + k) % 4;
                end
            end
        end
    endtask

    // One clock of the N=4 instance: check grant and output against the
    // model, pop on consumption, push on acceptance, then advance.
    task automatic cycle();
        bit f;
        int w;
        bit lo;
        logic [3:0]  exp_rdy;
        logic [33:0] e;
        #1;
        lo = !m_valid || out_ready;
        model_win(f, w);
        exp_rdy = 4'b0000;
        if (f && lo) exp_rdy[w] = 1'b1;
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, m_valid);
        if (m_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_chan", out_chan, e[33:32]);
                check("out_data", out_data, e[31:0]);
            end
        end
        if (f && lo) begin
            sb.push_back({w[1:0], dat[w]});
            m_valid = 1'b1;
            m_last  = w;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) dat[i] = 32'hA0 + i;
        in_valid = 4'b1111; sel_en = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_data3 = {8'h33, 8'h22, 8'h11};
        in_valid3 = 3'b000; sel_en3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
        model_reset();

        // Reset with all channels requesting
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("first_grant", in_ready, 4'b0001);

        // Round-robin, all valid, out_ready=1: chan 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_seq", out_chan, i % 4);
        end

        // Backpressure
        in_valid = 4'b0100; dat[2] = 32'hDEAD;
        cycle();
        check("bp_load", out_data, 32'hDEAD);
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold_data", out_data, 32'hDEAD);
            check("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_next_ch3", in_ready, 4'b1000);
        cycle();
        check("bp_chan3", out_chan, 3);
        dat[2] = 32'hA2;

        // Sparse: last=1 first, then channels 1 and 3
        in_valid = 4'b0010;
        cycle();
        in_valid = 4'b1010;
        cycle(); check("sparse_1", out_chan, 3);
        cycle(); check("sparse_2", out_chan, 1);
        cycle(); check("sparse_3", out_chan, 3);

        // Forced mode
        sel_en = 1'b1; sel = 2'd2; in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("forced_chan", out_chan, 2);
        end
        in_valid = 4'b1011;
        cycle();
        cycle();
        check("forced_drop", out_valid, 0);
        sel_en = 1'b0;

        // Async reset mid-stream
        in_valid = 4'b1111; out_ready = 1'b0;
        cycle();
        check("mid_loaded", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("mid_restart", out_chan, 0);
        cycle();
        check("mid_restart_1", out_chan, 1);

        // N=3 instance, out-of-range forced select
        in_valid3 = 3'b111; sel_en3 = 1'b1; sel3 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("n3_sel3_ready", in_ready3, 0);
            check("n3_sel3_valid", out_valid3, 0);
        end
        sel3 = 2'd1;
        #1;
        check("n3_sel1_ready", in_ready3, 3'b010);
        @(posedge clk);
        #1;
        check("n3_sel1_chan", out_chan3, 1);
        check("n3_sel1_data", out_data3, 8'h22);
        check("n3_sel1_valid", out_valid3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
